if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 117 +++++++++++
 tb/tb_if_stage.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction fetch stage: one outstanding fetch, a one-word skid buffer for stalls,
// and the IF/ID pipeline register with flush on redirect.
module if_stage (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [63:0] ifid_pc,
  output logic [10:0] ifid_opcode
);

  localparam logic [1:0] ST_ISSUE = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_DROP  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [31:0] buf_q, buf_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [63:0] ifpc_q, ifpc_d;
  logic        deliver;
  logic [31:0] word;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    buf_d   = buf_q;
    valid_d = valid_q;
    instr_d = instr_q;
    ifpc_d  = ifpc_q;
    deliver = 1'b0;
    word    = imem_rdata;

    case (state_q)
      ST_ISSUE: state_d = redirect ? ST_DROP : ST_WAIT;
      ST_WAIT: begin
        if (imem_ack) begin
          if (redirect) begin
            state_d = ST_ISSUE;
          end else if (stall) begin
            buf_d   = imem_rdata;
            state_d = ST_HOLD;
          end else begin
            deliver = 1'b1;
            state_d = ST_ISSUE;
          end
        end else if (redirect) begin
          state_d = ST_DROP;
        end
      end
      ST_HOLD: begin
        if (redirect) begin
          state_d = ST_ISSUE;
        end else if (!stall) begin
          deliver = 1'b1;
          word    = buf_q;
          state_d = ST_ISSUE;
        end
      end
      // An ack landing together with a redirect still retires the dropped fetch,
      // otherwise DROP would wait forever for an ack that already came.
      ST_DROP: if (imem_ack) state_d = ST_ISSUE;
      default: state_d = ST_ISSUE;
    endcase

    if (redirect) begin
      pc_d    = {redirect_pc[63:2], 2'b00};
      buf_d   = '0;
      valid_d = 1'b0;
      instr_d = '0;
    end else if (deliver) begin
      valid_d = 1'b1;
      instr_d = word;
      ifpc_d  = pc_q;
      pc_d    = pc_q + 64'd4;
    end else if (!stall) begin
      valid_d = 1'b0;
      instr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ISSUE;
      pc_q    <= '0;
      buf_q   <= '0;
      valid_q <= 1'b0;
      instr_q <= '0;
      ifpc_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
    end
  end

  // Gated by rst_n so the request drops immediately when reset asserts.
  assign imem_req    = rst_n && (state_q == ST_ISSUE);
  assign imem_addr   = pc_q;
  assign ifid_valid  = valid_q;
  assign ifid_instr  = instr_q;
  assign ifid_pc     = ifpc_q;
  assign ifid_opcode = instr_q[31:21];

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: memory acknowledgements, stalls and redirects are
// driven by hand and every output is compared against hand-computed values.
module tb_if_stage;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [63:0] ifid_pc;
  logic [10:0] ifid_opcode;

  int errors = 0;
  int checks = 0;

  if_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .ifid_valid (ifid_valid),
    .ifid_instr (ifid_instr),
    .ifid_pc    (ifid_pc),
    .ifid_opcode(ifid_opcode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0; stall = 1'b0;
    redirect = 1'b0; redirect_pc = '0;
    tick(); tick();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", imem_req); end
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", ifid_valid); end
    checks++; if (ifid_instr !== 32'h0) begin errors++; $display("FAIL reset_instr got=%h exp=0", ifid_instr); end
    checks++; if (ifid_pc !== 64'h0) begin errors++; $display("FAIL reset_pc got=%h exp=0", ifid_pc); end
    checks++; if (ifid_opcode !== 11'h0) begin errors++; $display("FAIL reset_opcode got=%h exp=0", ifid_opcode); end
    rst_n = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin errors++; $display("FAIL first_req got req=%b addr=%h exp req=1 addr=0", imem_req, imem_addr); end
  endtask

  task automatic test_first_fetch();
    tick();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL wait_req got=%b exp=0", imem_req); end
    imem_ack = 1'b1; imem_rdata = 32'hF800_0000;
    tick();
    imem_ack = 1'b0;
    checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 64'h0) begin errors++; $display("FAIL fetch0 got valid=%b pc=%h exp valid=1 pc=0", ifid_valid, ifid_pc); end
    checks++; if (ifid_opcode !== 11'b11111000000) begin errors++; $display("FAIL fetch0_opcode got=%b exp=11111000000", ifid_opcode); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h4) begin errors++; $display("FAIL fetch0_next got req=%b addr=%h exp req=1 addr=4", imem_req, imem_addr); end
  endtask

  task automatic test_back_to_back();
    tick();
    checks++; if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0) begin errors++; $display("FAIL bubble got valid=%b instr=%h exp 0/0", ifid_valid, ifid_instr); end
    imem_ack = 1'b1; imem_rdata = 32'hF840_0000;
    tick();
    imem_ack = 1'b0;
    checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 64'h4) begin errors++; $display("FAIL fetch1 got valid=%b pc=%h exp valid=1 pc=4", ifid_valid, ifid_pc); end
    checks++; if (ifid_opcode !== 11'b11111000010) begin errors++; $display("FAIL ldur_opcode got=%b exp=11111000010", ifid_opcode); end
    checks++; if (imem_addr !== 64'h8) begin errors++; $display("FAIL fetch1_next got=%h exp=8", imem_addr); end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    tick();
    checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 64'h4) begin errors++; $display("FAIL stall_hold_wait got valid=%b pc=%h exp 1/4", ifid_valid, ifid_pc); end
    imem_ack = 1'b1; imem_rdata = 32'h8B02_0020;
    tick();
    imem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (imem_req !== 1'b0 || ifid_valid !== 1'b1 || ifid_pc !== 64'h4 || ifid_instr !== 32'hF840_0000) begin
        errors++;
        $display("FAIL hold_cycle%0d got req=%b valid=%b pc=%h instr=%h exp 0/1/4/f8400000", i, imem_req, ifid_valid, ifid_pc, ifid_instr);
      end
      if (i == 2) stall = 1'b0;
      tick();
    end
    checks++; if (ifid_valid !== 1'b1 || ifid_instr !== 32'h8B02_0020 || ifid_pc !== 64'h8) begin errors++; $display("FAIL unstall_load got valid=%b instr=%h pc=%h exp 1/8b020020/8", ifid_valid, ifid_instr, ifid_pc); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 64'hC) begin errors++; $display("FAIL unstall_next got req=%b addr=%h exp 1/c", imem_req, imem_addr); end
  endtask

  task automatic test_redirect_wait();
    tick();
    redirect = 1'b1; redirect_pc = 64'h0000_0000_0000_0103;
    tick();
    redirect = 1'b0;
    checks++; if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0 || imem_req !== 1'b0) begin errors++; $display("FAIL redir_flush got valid=%b instr=%h req=%b exp 0/0/0", ifid_valid, ifid_instr, imem_req); end
    tick();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL drop_wait got req=%b exp=0", imem_req); end
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    checks++; if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0) begin errors++; $display("FAIL drop_discard got valid=%b instr=%h exp 0/0", ifid_valid, ifid_instr); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h100) begin errors++; $display("FAIL redir_target got req=%b addr=%h exp 1/100", imem_req, imem_addr); end
  endtask

  task automatic test_redirect_ack();
    tick();
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    redirect = 1'b1; redirect_pc = 64'h2000; stall = 1'b1;
    tick();
    imem_ack = 1'b0; redirect = 1'b0; stall = 1'b0;
    checks++; if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0) begin errors++; $display("FAIL redir_ack_flush got valid=%b instr=%h exp 0/0", ifid_valid, ifid_instr); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h2000) begin errors++; $display("FAIL redir_ack_issue got req=%b addr=%h exp 1/2000", imem_req, imem_addr); end
  endtask

  task automatic test_wrap();
    redirect = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    redirect = 1'b0;
    imem_ack = 1'b1; imem_rdata = 32'h0;
    tick();
    imem_ack = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wrap_issue got req=%b addr=%h exp 1/fffffffffffffffc", imem_req, imem_addr); end
    tick();
    imem_ack = 1'b1; imem_rdata = 32'h9100_0421;
    tick();
    imem_ack = 1'b0;
    checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wrap_ifid got valid=%b pc=%h exp 1/fffffffffffffffc", ifid_valid, ifid_pc); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin errors++; $display("FAIL wrap_next got req=%b addr=%h exp 1/0", imem_req, imem_addr); end
  endtask

  task automatic test_ack_violation();
    imem_ack = 1'b1; imem_rdata = 32'hCAFE_F00D;
    tick();
    imem_ack = 1'b0;
    checks++; if (ifid_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL issue_ack_ignored got valid=%b req=%b exp 0/0", ifid_valid, imem_req); end
    tick();
    checks++; if (imem_req !== 1'b0 || ifid_valid !== 1'b0) begin errors++; $display("FAIL still_wait got req=%b valid=%b exp 0/0", imem_req, ifid_valid); end
    imem_ack = 1'b1; imem_rdata = 32'hAA00_0000;
    tick();
    imem_ack = 1'b0;
    checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 64'h0 || ifid_instr !== 32'hAA00_0000) begin errors++; $display("FAIL post_violation got valid=%b pc=%h instr=%h exp 1/0/aa000000", ifid_valid, ifid_pc, ifid_instr); end
  endtask

  task automatic test_reset_mid();
    stall = 1'b1;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0 || imem_addr !== 64'h0) begin errors++; $display("FAIL async_req got req=%b addr=%h exp 0/0", imem_req, imem_addr); end
    checks++; if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0 || ifid_pc !== 64'h0 || ifid_opcode !== 11'h0) begin errors++; $display("FAIL async_ifid got valid=%b instr=%h pc=%h op=%h exp all 0", ifid_valid, ifid_instr, ifid_pc, ifid_opcode); end
    stall = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin errors++; $display("FAIL restart_req got req=%b addr=%h exp 1/0", imem_req, imem_addr); end
    tick();
    imem_ack = 1'b1; imem_rdata = 32'hF840_0000;
    tick();
    imem_ack = 1'b0;
    checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 64'h0 || imem_addr !== 64'h4) begin errors++; $display("FAIL restart_fetch got valid=%b pc=%h addr=%h exp 1/0/4", ifid_valid, ifid_pc, imem_addr); end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_back_to_back();
    test_stall();
    test_redirect_wait();
    test_redirect_ack();
    test_wrap();
    test_ack_violation();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
